// File: rtl/etapa_decodificacion_pkg.sv
// paquete_decodificacion: shared definitions for the RV32I decode stage.
//   - RV32I major opcodes used by decode and hazard detection
//   - default NOP instruction loaded into IF/ID on reset or flush
//   - immediate-format enum and instruction field positions
//   - tipo_de_opcode(): maps an opcode to its immediate format
// Configuration macro: BYPASS_WB_EN (consumed by the register file and the top).
package paquete_decodificacion;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // addi x0,x0,0
    localparam logic [31:0] INSTR_NOP_POR_DEFECTO = 32'h00000013;

    localparam int unsigned POS_RD_LSB  = 7;
    localparam int unsigned POS_RS1_LSB = 15;
    localparam int unsigned POS_RS2_LSB = 20;
    localparam int unsigned ANCHO_REG   = 5;

    typedef enum logic [2:0] {
        IMM_NINGUNO,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } tipo_imm_t;

    function automatic tipo_imm_t tipo_de_opcode(input logic [6:0] opcode);
        tipo_imm_t tipo;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: tipo = IMM_I;
            OP_STORE:                 tipo = IMM_S;
            OP_BRANCH:                tipo = IMM_B;
            OP_LUI, OP_AUIPC:         tipo = IMM_U;
            OP_JAL:                   tipo = IMM_J;
            default:                  tipo = IMM_NINGUNO;
        endcase
        return tipo;
    endfunction

endpackage

// File: rtl/etapa_decodificacion_banco_registros.sv
// banco_registros: RV32I integer register file, 2 read ports, 1 write port.
//   clk, reinicio_n          clock (rising edge), async active-low reset (clears all)
//   dir_lectura1/2           read addresses (combinational read)
//   dato_lectura1/2          read data; x0 always reads 0
//   escritura_habilitada     write enable (writes to x0 are dropped)
//   dir_escritura            write address
//   dato_escritura           write data
// BYPASS_WB_EN defined: a read hitting the address being written this cycle
// returns the incoming data instead of the stored value.
module banco_registros
    import paquete_decodificacion::*;
#(
    parameter int unsigned ANCHO_DATOS   = 32,
    parameter int unsigned NUM_REGISTROS = 32
)(
    input  logic                   clk,
    input  logic                   reinicio_n,
    input  logic [ANCHO_REG-1:0]   dir_lectura1,
    input  logic [ANCHO_REG-1:0]   dir_lectura2,
    output logic [ANCHO_DATOS-1:0] dato_lectura1,
    output logic [ANCHO_DATOS-1:0] dato_lectura2,
    input  logic                   escritura_habilitada,
    input  logic [ANCHO_REG-1:0]   dir_escritura,
    input  logic [ANCHO_DATOS-1:0] dato_escritura
);

    logic [ANCHO_DATOS-1:0] r_regs [NUM_REGISTROS];
    logic                   w_escribe;

    assign w_escribe = escritura_habilitada && (dir_escritura != '0);

    always_ff @(posedge clk or negedge reinicio_n) begin
        if (!reinicio_n) begin
            for (int unsigned i = 0; i < NUM_REGISTROS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_escribe) begin
            r_regs[dir_escritura] <= dato_escritura;
        end
    end

    always_comb begin
        dato_lectura1 = '0;
        dato_lectura2 = '0;
        if (dir_lectura1 != '0) begin
            dato_lectura1 = r_regs[dir_lectura1];
`ifdef BYPASS_WB_EN
            if (w_escribe && (dir_escritura == dir_lectura1)) dato_lectura1 = dato_escritura;
`endif
        end
        if (dir_lectura2 != '0) begin
            dato_lectura2 = r_regs[dir_lectura2];
`ifdef BYPASS_WB_EN
            if (w_escribe && (dir_escritura == dir_lectura2)) dato_lectura2 = dato_escritura;
`endif
        end
    end

endmodule

// File: rtl/etapa_decodificacion.sv
// etapa_decodificacion: RV32I decode stage feeding the ID/EX register.
//   Holds the IF/ID latch, the register file, immediate generation and
//   load-use hazard detection. Outputs are combinational from IF/ID + regfile.
// Ports:
//   clk, reinicio_n                    clock, async active-low reset
//   pc_entrada, instruccion_entrada    fetched PC / instruction
//   vaciar                             flush from EX (wins over stall)
//   escritura_habilitada_wb, registro_destino_wb, dato_wb   write-back port
//   lectura_mem_ex, registro_destino_ex                     load in EX
//   pc_salida, registro1_salida, registro2_salida, extension_signo_salida
//   registro_destino_salida, lectura_mem_salida, escritura_reg_salida,
//   valido_salida (0 = bubble), parar_if (hold PC/fetch)
// Configuration macro: BYPASS_WB_EN. When undefined, a pending write-back to
// a source register also stalls one cycle so the write lands before the read.
module etapa_decodificacion
    import paquete_decodificacion::*;
#(
    parameter int unsigned ANCHO_DATOS   = 32,
    parameter int unsigned NUM_REGISTROS = 32,
    parameter logic [31:0] INSTR_NOP     = INSTR_NOP_POR_DEFECTO
)(
    input  logic                   clk,
    input  logic                   reinicio_n,
    input  logic [ANCHO_DATOS-1:0] pc_entrada,
    input  logic [31:0]            instruccion_entrada,
    input  logic                   vaciar,
    input  logic                   escritura_habilitada_wb,
    input  logic [4:0]             registro_destino_wb,
    input  logic [ANCHO_DATOS-1:0] dato_wb,
    input  logic                   lectura_mem_ex,
    input  logic [4:0]             registro_destino_ex,
    output logic [ANCHO_DATOS-1:0] pc_salida,
    output logic [ANCHO_DATOS-1:0] registro1_salida,
    output logic [ANCHO_DATOS-1:0] registro2_salida,
    output logic [31:0]            extension_signo_salida,
    output logic [4:0]             registro_destino_salida,
    output logic                   lectura_mem_salida,
    output logic                   escritura_reg_salida,
    output logic                   valido_salida,
    output logic                   parar_if
);

    logic [ANCHO_DATOS-1:0] r_pc;
    logic [31:0]            r_instr;
    logic                   r_valido;

    logic [6:0]           w_opcode;
    logic [4:0]           w_rs1, w_rs2, w_rd;
    tipo_imm_t            w_tipo;
    logic [31:0]          w_imm;
    logic                 w_usa_rs1, w_usa_rs2, w_escribe_rd;
    logic                 w_riesgo_carga, w_riesgo_wb, w_riesgo, w_burbuja;

    assign w_opcode = r_instr[6:0];
    assign w_rd     = r_instr[POS_RD_LSB  +: ANCHO_REG];
    assign w_rs1    = r_instr[POS_RS1_LSB +: ANCHO_REG];
    assign w_rs2    = r_instr[POS_RS2_LSB +: ANCHO_REG];
    assign w_tipo   = tipo_de_opcode(w_opcode);

    always_comb begin
        w_imm = '0;
        case (w_tipo)
            IMM_I: w_imm = {{20{r_instr[31]}}, r_instr[31:20]};
            IMM_S: w_imm = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
            IMM_B: w_imm = {{19{r_instr[31]}}, r_instr[31], r_instr[7],
                            r_instr[30:25], r_instr[11:8], 1'b0};
            IMM_U: w_imm = {r_instr[31:12], 12'b0};
            IMM_J: w_imm = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12],
                            r_instr[20], r_instr[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    assign w_usa_rs1    = (w_tipo != IMM_U) && (w_tipo != IMM_J);
    assign w_usa_rs2    = (w_opcode == OP_REG) || (w_tipo == IMM_S) || (w_tipo == IMM_B);
    assign w_escribe_rd = (w_opcode == OP_REG) || (w_tipo == IMM_I) ||
                          (w_tipo == IMM_U) || (w_tipo == IMM_J);

    assign w_riesgo_carga = lectura_mem_ex && (registro_destino_ex != '0) &&
                            ((w_usa_rs1 && (registro_destino_ex == w_rs1)) ||
                             (w_usa_rs2 && (registro_destino_ex == w_rs2)));

`ifdef BYPASS_WB_EN
    assign w_riesgo_wb = 1'b0;
`else
    // Without the bypass, a same-cycle write-back to a source would be read
    // stale; stall one cycle so the stored value is current.
    assign w_riesgo_wb = escritura_habilitada_wb && (registro_destino_wb != '0) &&
                         ((w_usa_rs1 && (registro_destino_wb == w_rs1)) ||
                          (w_usa_rs2 && (registro_destino_wb == w_rs2)));
`endif

    assign w_riesgo  = r_valido && (w_riesgo_carga || w_riesgo_wb);
    assign parar_if  = w_riesgo && !vaciar;
    assign w_burbuja = w_riesgo || vaciar || !r_valido;

    always_ff @(posedge clk or negedge reinicio_n) begin
        if (!reinicio_n) begin
            r_pc     <= '0;
            r_instr  <= INSTR_NOP;
            r_valido <= 1'b0;
        end else if (vaciar) begin
            r_pc     <= '0;
            r_instr  <= INSTR_NOP;
            r_valido <= 1'b0;
        end else if (!parar_if) begin
            r_pc     <= pc_entrada;
            r_instr  <= instruccion_entrada;
            r_valido <= 1'b1;
        end
    end

    banco_registros #(
        .ANCHO_DATOS   (ANCHO_DATOS),
        .NUM_REGISTROS (NUM_REGISTROS)
    ) u_banco (
        .clk                  (clk),
        .reinicio_n           (reinicio_n),
        .dir_lectura1         (w_rs1),
        .dir_lectura2         (w_rs2),
        .dato_lectura1        (registro1_salida),
        .dato_lectura2        (registro2_salida),
        .escritura_habilitada (escritura_habilitada_wb),
        .dir_escritura        (registro_destino_wb),
        .dato_escritura       (dato_wb)
    );

    assign pc_salida               = r_pc;
    assign extension_signo_salida  = w_imm;
    assign valido_salida           = !w_burbuja;
    assign registro_destino_salida = w_burbuja ? 5'd0 : w_rd;
    assign lectura_mem_salida      = !w_burbuja && (w_opcode == OP_LOAD);
    assign escritura_reg_salida    = !w_burbuja && w_escribe_rd && (w_rd != 5'd0);

endmodule
